// File: rtl/lift_scan_if.sv
// Request/status bundle between button decode, motor/door drivers and lift_scan_ctrl.
// Requests are level or pulse: any bit high on a clock edge is latched, there is no back-pressure.
interface lift_scan_if #(
    parameter int NUM_FLOORS = 11,
    parameter int FLOOR_W    = 4
);
    logic [NUM_FLOORS-1:0] hall_req;
    logic [NUM_FLOORS-1:0] car_req;
    logic                  door_hold;
    logic [FLOOR_W-1:0]    curr_floor;
    logic [1:0]            motor_signal;
    logic                  door_open;
    logic                  dir_up;
    logic [NUM_FLOORS-1:0] pending;
    logic                  arrived;
    logic [1:0]            state_dbg;

    modport master (
        output hall_req, car_req, door_hold,
        input  curr_floor, motor_signal, door_open, dir_up, pending, arrived, state_dbg
    );

    modport slave (
        input  hall_req, car_req, door_hold,
        output curr_floor, motor_signal, door_open, dir_up, pending, arrived, state_dbg
    );
endinterface

// File: rtl/lift_scan_ctrl.sv
// Single-car LOOK elevator controller: merges hall/car calls into a pending vector,
// sweeps in one direction while calls remain ahead, and runs a door dwell state.
module lift_scan_ctrl #(
    parameter int NUM_FLOORS    = 11,
    parameter int FLOOR_W       = 4,
    parameter int TRAVEL_CYCLES = 2,
    parameter int DOOR_CYCLES   = 4
) (
    input  logic        clk,
    input  logic        rst,
    lift_scan_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MOVE = 2'd1,
        ST_DOOR = 2'd2
    } state_t;

    localparam int TCNT_W = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;
    localparam int DCNT_W = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
    localparam logic [TCNT_W-1:0]  TRAVEL_LAST = TCNT_W'(TRAVEL_CYCLES - 1);
    localparam logic [DCNT_W-1:0]  DOOR_LAST   = DCNT_W'(DOOR_CYCLES - 1);
    localparam logic [FLOOR_W-1:0] LAST_FLOOR  = FLOOR_W'(NUM_FLOORS - 1);
    localparam logic [1:0] MOTOR_STOP = 2'b00;
    localparam logic [1:0] MOTOR_UP   = 2'b11;
    localparam logic [1:0] MOTOR_DOWN = 2'b10;

    state_t                state;
    logic [FLOOR_W-1:0]    curr_floor;
    logic [1:0]            motor_signal;
    logic                  door_open;
    logic                  dir_up;
    logic [NUM_FLOORS-1:0] pending;
    logic                  arrived;
    logic [TCNT_W-1:0]     travel_cnt;
    logic [DCNT_W-1:0]     dwell_cnt;

    logic [NUM_FLOORS-1:0] req_all;
    logic [NUM_FLOORS-1:0] above_mask;
    logic [NUM_FLOORS-1:0] below_mask;
    logic [NUM_FLOORS-1:0] curr_onehot;
    logic [NUM_FLOORS-1:0] next_onehot;
    logic [NUM_FLOORS-1:0] clear;
    logic [FLOOR_W-1:0]    next_floor;
    logic                  any_above;
    logic                  any_below;
    logic                  call_here;
    logic                  travel_done;
    logic                  stop_next;

    always_comb begin
        req_all     = pending | bus.hall_req | bus.car_req;
        next_floor  = dir_up ? (curr_floor + FLOOR_W'(1)) : (curr_floor - FLOOR_W'(1));
        above_mask  = '0;
        below_mask  = '0;
        curr_onehot = '0;
        next_onehot = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            above_mask[i]  = (FLOOR_W'(i) > curr_floor);
            below_mask[i]  = (FLOOR_W'(i) < curr_floor);
            curr_onehot[i] = (FLOOR_W'(i) == curr_floor);
            next_onehot[i] = (FLOOR_W'(i) == next_floor);
        end
        any_above   = |(req_all & above_mask);
        any_below   = |(req_all & below_mask);
        call_here   = |(req_all & curr_onehot);
        travel_done = (state == ST_MOVE) && (travel_cnt == TRAVEL_LAST);
        stop_next   = travel_done && |(req_all & next_onehot);
        // Calls for the floor whose door is open (or opening this edge) are absorbed, never latched.
        clear = '0;
        if (state == ST_DOOR || (state == ST_IDLE && call_here)) begin
            clear = curr_onehot;
        end else if (stop_next) begin
            clear = next_onehot;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            curr_floor   <= '0;
            motor_signal <= MOTOR_STOP;
            door_open    <= 1'b0;
            dir_up       <= 1'b1;
            pending      <= '0;
            arrived      <= 1'b0;
            travel_cnt   <= '0;
            dwell_cnt    <= '0;
        end else begin
            pending <= req_all & ~clear;
            arrived <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (call_here) begin
                        state     <= ST_DOOR;
                        door_open <= 1'b1;
                        arrived   <= 1'b1;
                        dwell_cnt <= '0;
                    end else if (dir_up ? any_above : any_below) begin
                        state        <= ST_MOVE;
                        motor_signal <= dir_up ? MOTOR_UP : MOTOR_DOWN;
                        travel_cnt   <= '0;
                    end else if (dir_up ? any_below : any_above) begin
                        // LOOK reversal: nothing left ahead, sweep back the other way.
                        state        <= ST_MOVE;
                        dir_up       <= ~dir_up;
                        motor_signal <= dir_up ? MOTOR_DOWN : MOTOR_UP;
                        travel_cnt   <= '0;
                    end
                end
                ST_MOVE: begin
                    if (travel_done) begin
                        curr_floor <= next_floor;
                        travel_cnt <= '0;
                        if (stop_next) begin
                            state        <= ST_DOOR;
                            motor_signal <= MOTOR_STOP;
                            door_open    <= 1'b1;
                            arrived      <= 1'b1;
                            dwell_cnt    <= '0;
                        end
                    end else begin
                        travel_cnt <= travel_cnt + TCNT_W'(1);
                    end
                end
                ST_DOOR: begin
                    if (bus.door_hold) begin
                        dwell_cnt <= '0;
                    end else if (dwell_cnt == DOOR_LAST) begin
                        state     <= ST_IDLE;
                        door_open <= 1'b0;
                    end else begin
                        dwell_cnt <= dwell_cnt + DCNT_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    a_floor_range: assert property (@(posedge clk) disable iff (rst)
        curr_floor <= LAST_FLOOR);

    a_no_overrun: assert property (@(posedge clk) disable iff (rst)
        travel_done |-> (dir_up ? (curr_floor != LAST_FLOOR) : (curr_floor != '0)));

    assign bus.curr_floor   = curr_floor;
    assign bus.motor_signal = motor_signal;
    assign bus.door_open    = door_open;
    assign bus.dir_up       = dir_up;
    assign bus.pending      = pending;
    assign bus.arrived      = arrived;
    assign bus.state_dbg    = state;
endmodule

// File: tb/tb_lift_scan_ctrl.sv
// Directed bench for lift_scan_ctrl: default 11-floor car plus a 2-floor corner instance.
module tb_lift_scan_ctrl;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MOVE = 2'd1;
    localparam logic [1:0] S_DOOR = 2'd2;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    lift_scan_if #(.NUM_FLOORS(11), .FLOOR_W(4)) u_if ();
    lift_scan_if #(.NUM_FLOORS(2),  .FLOOR_W(1)) c_if ();

    lift_scan_ctrl #(.NUM_FLOORS(11), .FLOOR_W(4), .TRAVEL_CYCLES(2), .DOOR_CYCLES(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if)
    );

    lift_scan_ctrl #(.NUM_FLOORS(2), .FLOOR_W(1), .TRAVEL_CYCLES(1), .DOOR_CYCLES(1)) dut_c (
        .clk (clk),
        .rst (rst),
        .bus (c_if)
    );

    always #5 clk = ~clk;

    // Observation layout: {floor, motor, door_open, arrived, dir_up, state, pending}
    logic [21:0] obs;
    logic [21:0] exp_v;
    logic [9:0]  obs_c;
    assign obs   = {u_if.curr_floor, u_if.motor_signal, u_if.door_open, u_if.arrived,
                    u_if.dir_up, u_if.state_dbg, u_if.pending};
    assign obs_c = {c_if.curr_floor, c_if.motor_signal, c_if.door_open, c_if.arrived,
                    c_if.dir_up, c_if.state_dbg, c_if.pending};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        u_if.hall_req  = '0;
        u_if.car_req   = '0;
        u_if.door_hold = 1'b0;
        c_if.hall_req  = '0;
        c_if.car_req   = '0;
        c_if.door_hold = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic set_exp(input int f, input logic [1:0] st, input logic dr,
                           input logic arr, input logic [10:0] p);
        logic [1:0] m;
        m = (st == S_MOVE) ? (dr ? 2'b11 : 2'b10) : 2'b00;
        exp_v = {4'(f), m, (st == S_DOOR), arr, dr, st, p};
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        u_if.hall_req = '1;
        c_if.car_req  = '1;
        tick();
        tick();
        set_exp(0, S_IDLE, 1'b1, 1'b0, 11'h000);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL reset_main got %h want %h", obs, exp_v);
        end
        n_checks++;
        if (obs_c !== 10'b0_00_0_0_1_00_00) begin
            n_fail++;
            $display("FAIL reset_corner got %b want %b", obs_c, 10'b0_00_0_0_1_00_00);
        end
        clear_inputs();
        rst = 1'b0;
    endtask

    task automatic test_single_call_up();
        logic [1:0] st;
        int f;
        do_reset();
        for (int e = 0; e <= 11; e++) begin
            if (e == 0) u_if.hall_req = 11'h1 << 3;
            tick();
            clear_inputs();
            f  = (e >= 6) ? 3 : e / 2;
            st = (e < 6) ? S_MOVE : (e < 10) ? S_DOOR : S_IDLE;
            set_exp(f, st, 1'b1, (e == 6), (e < 6) ? (11'h1 << 3) : 11'h000);
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL single_call_up e=%0d got %h want %h", e, obs, exp_v);
            end
        end
    endtask

    task automatic test_pickup_on_way();
        logic [1:0]  st;
        logic [10:0] p;
        int f;
        do_reset();
        for (int e = 0; e <= 26; e++) begin
            if (e == 0)  u_if.car_req  = 11'h1 << 8;
            if (e == 3)  u_if.hall_req = 11'h1 << 5;
            if (e == 21) u_if.hall_req = 11'h1 << 8;
            tick();
            clear_inputs();
            f  = (e < 10) ? e / 2 : (e < 17) ? 5 : (e < 19) ? 6 : (e < 21) ? 7 : 8;
            st = (e < 10) ? S_MOVE : (e < 14) ? S_DOOR : (e < 15) ? S_IDLE :
                 (e < 21) ? S_MOVE : (e < 25) ? S_DOOR : S_IDLE;
            p  = (e < 3) ? (11'h1 << 8) : (e < 10) ? ((11'h1 << 8) | (11'h1 << 5)) :
                 (e < 21) ? (11'h1 << 8) : 11'h000;
            set_exp(f, st, 1'b1, (e == 10 || e == 21), p);
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL pickup_on_way e=%0d got %h want %h", e, obs, exp_v);
            end
        end
    endtask

    task automatic test_look_reversal();
        logic [1:0]  st;
        logic [10:0] p;
        int f;
        do_reset();
        for (int e = 0; e <= 39; e++) begin
            if (e == 0) u_if.car_req = 11'h1 << 5;
            if (e == 11) begin
                u_if.car_req  = 11'h1 << 2;
                u_if.hall_req = 11'h1 << 7;
            end
            tick();
            clear_inputs();
            f  = (e < 10) ? e / 2 : (e < 17) ? 5 : (e < 19) ? 6 : (e < 26) ? 7 :
                 (e < 28) ? 6 : (e < 30) ? 5 : (e < 32) ? 4 : (e < 34) ? 3 : 2;
            st = (e < 10) ? S_MOVE : (e < 14) ? S_DOOR : (e < 15) ? S_IDLE :
                 (e < 19) ? S_MOVE : (e < 23) ? S_DOOR : (e < 24) ? S_IDLE :
                 (e < 34) ? S_MOVE : (e < 38) ? S_DOOR : S_IDLE;
            p  = (e < 10) ? (11'h1 << 5) : (e < 11) ? 11'h000 :
                 (e < 19) ? ((11'h1 << 2) | (11'h1 << 7)) : (e < 34) ? (11'h1 << 2) : 11'h000;
            set_exp(f, st, (e < 24), (e == 10 || e == 19 || e == 34), p);
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL look_reversal e=%0d got %h want %h", e, obs, exp_v);
            end
        end
    endtask

    task automatic test_door_hold();
        logic [1:0] st;
        int f;
        do_reset();
        for (int e = 0; e <= 24; e++) begin
            if (e == 0) u_if.car_req = 11'h1 << 4;
            if (e >= 9 && e <= 14) u_if.door_hold = 1'b1;
            if (e == 10 || e == 12 || e == 19) u_if.hall_req = 11'h1 << 4;
            tick();
            clear_inputs();
            f  = (e < 8) ? e / 2 : 4;
            st = (e < 8) ? S_MOVE : (e < 18) ? S_DOOR : (e < 19) ? S_IDLE :
                 (e < 23) ? S_DOOR : S_IDLE;
            set_exp(f, st, 1'b1, (e == 8 || e == 19), (e < 8) ? (11'h1 << 4) : 11'h000);
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL door_hold e=%0d got %h want %h", e, obs, exp_v);
            end
        end
    endtask

    task automatic test_two_floor_corner();
        logic [9:0] tbl [0:6];
        tbl[0] = 10'b0_11_0_0_1_01_10;
        tbl[1] = 10'b1_00_1_1_1_10_00;
        tbl[2] = 10'b1_00_0_0_1_00_01;
        tbl[3] = 10'b1_10_0_0_0_01_01;
        tbl[4] = 10'b0_00_1_1_0_10_00;
        tbl[5] = 10'b0_00_0_0_0_00_00;
        tbl[6] = 10'b0_00_0_0_0_00_00;
        do_reset();
        for (int e = 0; e <= 6; e++) begin
            if (e == 0) c_if.car_req = 2'b10;
            if (e == 2) c_if.car_req = 2'b01;
            tick();
            clear_inputs();
            n_checks++;
            if (obs_c !== tbl[e]) begin
                n_fail++;
                $display("FAIL two_floor_corner e=%0d got %b want %b", e, obs_c, tbl[e]);
            end
        end
    endtask

    task automatic test_reset_mid_move();
        logic [10:0] p;
        do_reset();
        for (int e = 0; e <= 6; e++) begin
            if (e == 0) begin
                u_if.hall_req = 11'h1 << 6;
                u_if.car_req  = 11'h1 << 6;
            end
            if (e == 1) u_if.hall_req = 11'h1 << 9;
            rst = (e == 5);
            tick();
            clear_inputs();
            rst = 1'b0;
            p = (e == 0) ? (11'h1 << 6) : ((11'h1 << 6) | (11'h1 << 9));
            if (e < 5) set_exp(e / 2, S_MOVE, 1'b1, 1'b0, p);
            else       set_exp(0, S_IDLE, 1'b1, 1'b0, 11'h000);
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL reset_mid_move e=%0d got %h want %h", e, obs, exp_v);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_single_call_up();
        test_pickup_on_way();
        test_look_reversal();
        test_door_hold();
        test_two_floor_corner();
        test_reset_mid_move();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/lift_scan_ctrl.md
# lift_scan_ctrl

Parametrised single-car elevator controller: the next generation of our lift block. It latches hall and in-car requests into one pending vector and serves them with a LOOK (elevator) policy, keeping its direction while requests remain ahead and reversing only when none do. It adds configurable floor count, travel time and door dwell, a door state machine with a hold input, and per-floor pending visibility. It sits between the hall/car button decode and the motor/door drivers.

## Interface
- NUM_FLOORS, 11, number of floors (0..NUM_FLOORS-1), min 2
- FLOOR_W, 4, width of floor index, must satisfy 2^FLOOR_W >= NUM_FLOORS
- TRAVEL_CYCLES, 2, cycles to move one floor, min 1
- DOOR_CYCLES, 4, cycles door stays open, min 1

- clk  in  1  single clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- hall_req  in  NUM_FLOORS  per-floor hall call; level or pulse, each set bit ORed into pending
- car_req  in  NUM_FLOORS  per-floor in-car destination, ORed into pending
- door_hold  in  1  while high in DOOR, dwell counter reloads
- curr_floor  out  FLOOR_W  current floor
- motor_signal  out  2  00 idle/stopped, 11 up, 10 down
- door_open  out  1  high while in DOOR
- dir_up  out  1  current/last travel direction, 1 = up
- pending  out  NUM_FLOORS  outstanding requests
- arrived  out  1  one-cycle pulse on the edge the car stops at a floor

## Operation
- States: IDLE, MOVE, DOOR. Reset: IDLE, curr_floor=0, motor_signal=00, door_open=0, dir_up=1, pending=0, arrived=0, counters=0.
- Request merge each edge: pending <= (pending | hall_req | car_req) & ~clear, where clear is the curr_floor bit while in DOOR or entering DOOR. The merged value (req_all) is used for all decisions in the same cycle.
- IDLE decision uses req_all. Priority:
  - bit at curr_floor: go to DOOR, clear it, pulse arrived.
  - any bit ahead in dir_up direction: go to MOVE in that direction.
  - any bit in the opposite direction: flip dir_up, then MOVE.
  - else stay IDLE.
- MOVE: motor_signal = 11 if dir_up, else 10. The travel counter counts TRAVEL_CYCLES cycles. On the last one, curr_floor steps by ±1 and the counter reloads.
  - If req_all[next floor] is set: go to DOOR, motor_signal=00, clear that bit, arrived=1.
  - Else keep moving. A request ahead always exists in MOVE, so no reversal happens in MOVE.
- curr_floor never goes below 0 or above NUM_FLOORS-1. Treat a violation as an assertion failure.
- DOOR: door_open=1 and motor_signal=00. The dwell counter counts DOOR_CYCLES cycles and reloads on any cycle with door_hold=1. New requests for curr_floor are absorbed and never set pending. When dwell expires: go to IDLE with door_open=0.
- Requests for other floors arriving in MOVE/DOOR are latched and served in LOOK order. Floors passed behind the car wait for the reverse sweep.

## Timing
- All outputs are registered.
- Request latency: a request sampled at edge E sets pending at E. From IDLE, motor_signal goes nonzero at E itself, so there is no extra cycle.
- Floor step: curr_floor changes on every TRAVEL_CYCLES-th edge after entering MOVE.
- Door dwell: door_open is high for exactly DOOR_CYCLES cycles, extended by door_hold. There is 1 IDLE cycle minimum after close before any MOVE or re-open.
- arrived is high for exactly 1 cycle, coincident with the first door_open cycle.
- Simultaneous hall_req and car_req on the same bit: treated as one request.
- Request for the floor the car is just arriving at on the stop edge: served by that stop, not re-latched.
- rst mid-operation (any state): all state returns to reset values on that edge, and pending requests are lost.

## Test plan
- Single call up, defaults: reset at floor 0; hall_req[3] for 1 cycle at edge 0.
  - Required: motor=11 from edge 0; curr_floor 1/2/3 at edges 2/4/6.
  - At edge 6: door_open=1, arrived pulse, pending=0.
  - door_open falls at edge 10; IDLE with motor=00.
- Pick-up on the way: car moving up from 0 toward car_req[8]; at edge 3 assert hall_req[5].
  - Required: stops at 5 (door 4 cycles), then resumes to 8; both pending bits cleared on arrival.
- LOOK reversal: at floor 5 going up, pending={2,7}.
  - Required: serves 7 first, dir_up stays 1 until the IDLE after 7, then flips to 0 and serves 2.
- Door hold and same-floor call: in DOOR at floor 4, door_hold high 6 cycles, hall_req[4] pulsed.
  - Required: door_open stays high for 6+DOOR_CYCLES cycles; pending[4] never set; no second arrived.
- Parameter corner (NUM_FLOORS=2, TRAVEL_CYCLES=1, DOOR_CYCLES=1): car_req[1] then car_req[0].
  - Required: floor 1 after 1 edge, 1-cycle door, 1 IDLE, then down to 0; curr_floor stays in {0,1}.
- Reset mid-move: rst high for 1 edge while MOVE between floors 2 and 3.
  - Required: on the next edge curr_floor=0, motor=00, pending=0, IDLE, dir_up=1.
